// File: rtl/serial_pkg.sv
// Shared definitions for the serial-to-parallel word aligner: comma
// patterns, FSM state encoding and the default word width.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 10;

    // K28.5 in both running disparities, first-received bit in bit 9.
    localparam logic [9:0] COMMA_RDN = 10'b0011111010;
    localparam logic [9:0] COMMA_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [9:0] word);
        return (word == COMMA_RDN) || (word == COMMA_RDP);
    endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational K28.5 detector over a 10-bit window, either disparity.
module comma_detect
    import serial_pkg::*;
(
    input  logic [9:0] word,
    output logic       match
);

    assign match = is_comma(word);

endmodule

// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel converter with comma-based word alignment.
// Optional build macro SP_COMMA_STRIP_EN drops aligned comma words in LOCKED.
module serial_paralelo_sync
    import serial_pkg::*;
#(
    parameter int CANTIDAD_BITS = DEFAULT_WIDTH,
    parameter int LOCK_COMMAS   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic                     entrada,
    output logic [CANTIDAD_BITS-1:0] salida,
    output logic                     valid,
    output logic                     es_comma,
    output logic                     locked,
    output logic [1:0]               estado
);

    localparam logic [3:0] LAST_BIT  = 4'(CANTIDAD_BITS - 1);
    localparam logic [2:0] LOCK_HITS = 3'(LOCK_COMMAS);

    state_t                   state, state_d;
    logic [CANTIDAD_BITS-1:0] shreg;
    logic [CANTIDAD_BITS-1:0] nxt;
    logic [3:0]               cnt, cnt_d;
    logic [2:0]               hits, hits_d;
    logic [CANTIDAD_BITS-1:0] salida_d;
    logic                     valid_d;
    logic                     es_comma_d;
    logic                     match;
    logic                     word_done;

    assign nxt       = {shreg[CANTIDAD_BITS-2:0], entrada};
    assign word_done = (cnt == LAST_BIT);
    assign estado    = state;

    comma_detect u_comma_detect (
        .word  (nxt[9:0]),
        .match (match)
    );

    // Valid/data contract: valid is a single-cycle strobe; salida is only
    // meaningful in the cycle valid is high and holds until the next strobe.
    always_comb begin
        state_d    = state;
        cnt_d      = word_done ? 4'd0 : cnt + 4'd1;
        hits_d     = hits;
        salida_d   = salida;
        valid_d    = 1'b0;
        es_comma_d = es_comma;

        case (state)
            SEARCH: begin
                if (match) begin
                    state_d = CONFIRM;
                    cnt_d   = 4'd0;
                    hits_d  = 3'd1;
                end
            end

            CONFIRM: begin
                if (word_done) begin
                    if (match) begin
                        hits_d = hits + 3'd1;
                        if ((hits + 3'd1) == LOCK_HITS) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d = SEARCH;
                        hits_d  = 3'd0;
                    end
                end else if (match) begin
                    cnt_d  = 4'd0;
                    hits_d = 3'd1;
                end
            end

            LOCKED: begin
                if (word_done) begin
`ifdef SP_COMMA_STRIP_EN
                    if (!match) begin
                        salida_d   = nxt;
                        valid_d    = 1'b1;
                        es_comma_d = 1'b0;
                    end
`else
                    salida_d   = nxt;
                    valid_d    = 1'b1;
                    es_comma_d = match;
`endif
                end else if (match) begin
                    // A comma off the word grid means we slipped: realign.
                    state_d = CONFIRM;
                    cnt_d   = 4'd0;
                    hits_d  = 3'd1;
                end
            end

            default: begin
                state_d = SEARCH;
                cnt_d   = 4'd0;
                hits_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            shreg    <= '0;
            cnt      <= 4'd0;
            hits     <= 3'd0;
            salida   <= '0;
            valid    <= 1'b0;
            es_comma <= 1'b0;
            locked   <= 1'b0;
        end else if (enb) begin
            state    <= state_d;
            shreg    <= nxt;
            cnt      <= cnt_d;
            hits     <= hits_d;
            salida   <= salida_d;
            valid    <= valid_d;
            es_comma <= es_comma_d;
            locked   <= (state_d == LOCKED);
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: doc/serial_paralelo_sync.md
SERIAL_PARALELO_SYNC -- requirements
Module: serial_paralelo_sync

Interface
REQ-001 Parameter: CANTIDAD_BITS, 10, word width in bits.
REQ-002 Parameter: LOCK_COMMAS, 3, number of consecutive aligned commas required for lock (range 2..7).
REQ-003 Port: clk  input  1  clock; all state updates on posedge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: enb  input  1  enable; when low, all state holds and valid is 0.
REQ-006 Port: entrada  input  1  serial bit stream, MSB of each word first.
REQ-007 Port: salida  output  CANTIDAD_BITS  last aligned word; bit 9 is the first-received bit.
REQ-008 Port: valid  output  1  one-cycle strobe; salida holds a new word.
REQ-009 Port: es_comma  output  1  qualifies salida as K28.5, either disparity; meaningful only with valid.
REQ-010 Port: locked  output  1  high while the FSM is in LOCKED.

Function
REQ-011 The shift register SHALL update as shreg <= {shreg[8:0], entrada} on every enabled edge; nxt denotes that shifted value.
REQ-012 Comma match SHALL be nxt == 10'b0011111010 or nxt == 10'b1100000101.
REQ-013 The 4-bit counter cnt SHALL count bits of the current word: on a word-completing edge it SHALL load 0, otherwise increment; a word completes on an enabled edge with cnt == 9.
REQ-014 FSM states SHALL be SEARCH, CONFIRM and LOCKED.
REQ-015 SEARCH: any comma match -> CONFIRM, cnt <= 0, hits <= 1; otherwise stay, with cnt free-running but ignored.
REQ-016 CONFIRM, word-completing edge: comma -> hits+1, and when hits+1 == LOCK_COMMAS -> LOCKED; non-comma -> SEARCH, hits <= 0.
REQ-017 CONFIRM or LOCKED, comma match on a non-completing edge (misaligned) -> CONFIRM, cnt <= 0, hits <= 1 (realign).
REQ-018 LOCKED, word-completing edge: salida <= nxt, valid <= 1, es_comma <= comma match; at every other edge valid <= 0.
REQ-019 The word that completes lock SHALL NOT raise valid; the first valid is for the next completed word.
REQ-020 Latency SHALL be valid and salida updating on the same edge that shifts in the word's 10th bit.
REQ-021 locked SHALL be registered and SHALL equal (state == LOCKED) after each edge.
REQ-022 salida SHALL hold its value between valid strobes.

Reset
REQ-023 On rst: shreg = 0, cnt = 0, hits = 0, state = SEARCH, salida = 0, valid = 0, es_comma = 0, locked = 0.
REQ-024 rst SHALL take priority over enb and all data events, including mid-word and mid-CONFIRM.
REQ-025 With enb low, no state update and no valid SHALL occur; bit alignment resumes unchanged when enb rises.

Configuration
REQ-026 Macro SP_COMMA_STRIP_EN: when defined, aligned comma words in LOCKED SHALL NOT raise valid and SHALL NOT update salida (idle commas stripped).
REQ-027 Without SP_COMMA_STRIP_EN, comma words SHALL be delivered with valid = 1 and es_comma = 1.

Structure
REQ-028 Package serial_pkg SHALL hold the COMMA_RDN/COMMA_RDP constants, the state typedef (SEARCH/CONFIRM/LOCKED) and the default word width.
REQ-029 Sub-module comma_detect (combinational, 10-bit in, match out) SHALL be instantiated once on nxt.

Verification
REQ-030 Scenario: rst, then 3x 0011111010 MSB-first -> locked rises on the 30th enabled edge; valid stays 0 through that edge.
REQ-031 Scenario: lock, then words 10'h2AA, 10'h155 -> valid pulses every 10 edges with salida = 10'h2AA then 10'h155, es_comma = 0.
REQ-032 Scenario: lock, then insert 3 stray bits, then 1100000101 -> locked falls on the comma edge; relock after 2 more aligned commas.
REQ-033 Scenario: one comma, then 10'h2AA at the boundary -> state returns to SEARCH and locked stays 0.
REQ-034 Scenario: enb low for 7 cycles mid-word while LOCKED -> no valid; next word is still correctly aligned.
REQ-035 Scenario: rst asserted mid-word while LOCKED -> all outputs 0 on the next edge; a build with SP_COMMA_STRIP_EN emits no valid for comma words.
